spm_acc_engine: RTL

//  Accumulation engine of the sparse polynomial multiplier: computes c = sum(+/-x^pos * a) mod (x^N+1, Q).

---
 rtl/spm_acc_engine.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/spm_acc_engine.sv
// Accumulation engine for the sparse polynomial multiplier.
// Computes c = sum(+/- x^pos * a) mod (x^N+1, Q) by read-modify-write into an
// external dual-port accumulator RAM. Port 0 reads and clears, port 1 writes
// back and clears. The a[] stream comes from a public-poly RAM with 1-cycle
// registered read latency.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in WAIT_CMD, does not depend
// on cmd_valid, and the command fields are sampled on that same edge.
module spm_acc_engine #(
    parameter int N     = 512,
    parameter int WIDTH = 8,
    parameter int Q     = 251
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [$clog2(N)-1:0]   cmd_pos,
    input  logic                   cmd_neg,
    input  logic                   cmd_last,
    output logic [$clog2(N)-1:0]   a_addr,
    input  logic [WIDTH-1:0]       a_q,
    output logic [$clog2(N)-1:0]   acc_address_0,
    output logic [WIDTH-1:0]       acc_data_0,
    output logic                   acc_wren_0,
    input  logic [WIDTH-1:0]       acc_q_0,
    output logic [$clog2(N)-1:0]   acc_address_1,
    output logic [WIDTH-1:0]       acc_data_1,
    output logic                   acc_wren_1
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0]  CLR_LAST = AW'(N / 2 - 1);
    localparam logic [AW-1:0]  RUN_LAST = AW'(N - 1);
    localparam logic [AW:0]    N_EXT    = (AW + 1)'(N);
    localparam logic [WIDTH-1:0] Q_W    = WIDTH'(Q);
    localparam logic [WIDTH:0]   Q_T    = (WIDTH + 1)'(Q);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_CMD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state, state_next;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   pos_r;
    logic            neg_r;
    logic            last_r;

    // Pipeline: issue (address presented) -> compute (RAM data back) -> write.
    logic            iss_valid;
    logic            iss_wrap;
    logic            cmp_valid;
    logic            cmp_s;
    logic [AW-1:0]   cmp_addr;

    logic [AW-1:0]   nxt_i;
    logic [AW:0]     nxt_k;
    logic [AW:0]     nxt_k_sub;
    logic            nxt_wrap;
    logic [AW-1:0]   nxt_addr;
    logic [AW-1:0]   clr_m;

    logic [WIDTH-1:0] add_v;
    logic [WIDTH:0]   t_v;
    logic [WIDTH:0]   t_sub;
    logic [WIDTH-1:0] r_v;

    assign acc_data_0 = '0;

    // Next RUN index and its negacyclic target address.
    assign nxt_i     = cnt + AW'(1);
    assign nxt_k     = {1'b0, nxt_i} + {1'b0, pos_r};
    assign nxt_k_sub = nxt_k - N_EXT;
    assign nxt_wrap  = (nxt_k >= N_EXT);
    assign nxt_addr  = nxt_wrap ? nxt_k_sub[AW-1:0] : nxt_k[AW-1:0];

    // CLEAR pair index m covering addresses 2m and 2m+1.
    assign clr_m = (state == S_IDLE) ? '0 : nxt_i;

    // Modular add of +/-a into the accumulator word; t carries one extra bit.
    assign add_v = (cmp_s && (a_q != '0)) ? (Q_W - a_q) : a_q;
    assign t_v   = {1'b0, acc_q_0} + {1'b0, add_v};
    assign t_sub = t_v - Q_T;
    assign r_v   = (t_v >= Q_T) ? t_sub[WIDTH-1:0] : t_v[WIDTH-1:0];

    // State register and per-state cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + AW'(1);
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        cmd_ready  = (state == S_WAIT_CMD);
        case (state)
            S_IDLE:     if (start) state_next = S_CLEAR;
            S_CLEAR:    if (cnt == CLR_LAST) state_next = S_WAIT_CMD;
            S_WAIT_CMD: if (cmd_valid) state_next = S_RUN;
            S_RUN:      if (cnt == RUN_LAST) state_next = S_DRAIN;
            S_DRAIN:    if (cnt == AW'(1)) state_next = last_r ? S_DONE : S_WAIT_CMD;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Latch the accepted command for the whole RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_r  <= '0;
            neg_r  <= 1'b0;
            last_r <= 1'b0;
        end else if (state == S_WAIT_CMD && cmd_valid) begin
            pos_r  <= cmd_pos;
            neg_r  <= cmd_neg;
            last_r <= cmd_last;
        end
    end

    // Registered RAM-facing outputs: clear sweep, RUN address issue, write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_addr        <= '0;
            acc_address_0 <= '0;
            acc_wren_0    <= 1'b0;
            acc_address_1 <= '0;
            acc_data_1    <= '0;
            acc_wren_1    <= 1'b0;
            iss_valid     <= 1'b0;
            iss_wrap      <= 1'b0;
            cmp_valid     <= 1'b0;
            cmp_s         <= 1'b0;
            cmp_addr      <= '0;
        end else begin
            acc_wren_0 <= 1'b0;
            acc_wren_1 <= 1'b0;
            iss_valid  <= 1'b0;
            cmp_valid  <= iss_valid;
            cmp_s      <= neg_r ^ iss_wrap;
            cmp_addr   <= acc_address_0;

            if ((state == S_IDLE && start) || (state == S_CLEAR && cnt != CLR_LAST)) begin
                acc_wren_0    <= 1'b1;
                acc_address_0 <= {clr_m[AW-2:0], 1'b0};
                acc_wren_1    <= 1'b1;
                acc_address_1 <= {clr_m[AW-2:0], 1'b1};
                acc_data_1    <= '0;
            end

            if (state == S_WAIT_CMD && cmd_valid) begin
                a_addr        <= '0;
                acc_address_0 <= cmd_pos;
                iss_wrap      <= 1'b0;
                iss_valid     <= 1'b1;
            end else if (state == S_RUN && cnt != RUN_LAST) begin
                a_addr        <= nxt_i;
                acc_address_0 <= nxt_addr;
                iss_wrap      <= nxt_wrap;
                iss_valid     <= 1'b1;
            end

            if (cmp_valid) begin
                acc_wren_1    <= 1'b1;
                acc_address_1 <= cmp_addr;
                acc_data_1    <= r_v;
            end
        end
    end

endmodule
